dp_test_axi_regs: RTL

AXI4-Lite slave (responder) register bank for the DP test pattern path; the far end of the AXI4-Lite master used to configure the video test generator. Holds the timing/colour configuration words (0x00–0x48) and exposes them as static outputs to the video timing/pattern logic. Also returns a read-only status word supplied by the video side. Single clock domain (ACLK); any crossing into VCLK is done outside this block.

---
 rtl/dp_test_axi_regs.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dp_test_axi_regs.sv
`default_nettype none
// ============================================================================
//  Module   : dp_test_axi_regs
//  Purpose  : AXI4-Lite register bank holding the DP test-pattern timing and
//             colour configuration words, plus a read-only video status word.
//             Optional macro DP_TEST_AXI_REGS_WSTRB_EN enables byte-lane writes.
//  Revision : 1.0  initial release
// ============================================================================
module dp_test_axi_regs #(
    parameter int          C_ADDR_W   = 16,
    parameter int          C_NUM_REGS = 19,
    parameter logic [31:0] C_CTRL_RST = 32'h1
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [C_ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic [3:0]                 S_AXI_AWCACHE,
    input  logic [2:0]                 S_AXI_AWPROT,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [31:0]                S_AXI_WDATA,
    input  logic [3:0]                 S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    output logic [1:0]                 S_AXI_BRESP,
    input  logic [C_ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic [3:0]                 S_AXI_ARCACHE,
    input  logic [2:0]                 S_AXI_ARPROT,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [31:0]                S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    input  logic [31:0]                STATUS,
    output logic [C_NUM_REGS*32-1:0]   CFG,
    output logic                       SOFT_RST
);

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_DATA      = 2'd1;
    localparam logic [1:0] W_ADDR      = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;
    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_DATA      = 1'b1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]          wr_state, wr_state_nxt;
    logic [0:0]          rd_state, rd_state_nxt;
    logic                rst_done;
    logic                aw_hs, w_hs, ar_hs, wr_commit;
    logic [C_ADDR_W-1:0] awaddr_q, wr_addr;
    logic [31:0]         wdata_q, wr_data, wr_mask;
    logic [3:0]          wstrb_q, wr_strb;
    logic [4:0]          wr_idx, rd_idx;
    logic                wr_ok;
    logic [31:0]         rd_word;
    logic [1:0]          rd_resp;

    // Readies stay low while reset is asserted and for the first edge after it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) wr_state <= W_IDLE;
        else          wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_commit    = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_nxt = W_RESP;
                    wr_commit    = 1'b1;
                end else if (aw_hs) begin
                    wr_state_nxt = W_DATA;
                end else if (w_hs) begin
                    wr_state_nxt = W_ADDR;
                end
            end
            W_DATA: if (w_hs) begin
                wr_state_nxt = W_RESP;
                wr_commit    = 1'b1;
            end
            W_ADDR: if (aw_hs) begin
                wr_state_nxt = W_RESP;
                wr_commit    = 1'b1;
            end
            W_RESP: if (S_AXI_BREADY) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                S_AXI_AWREADY = rst_done;
                S_AXI_WREADY  = rst_done;
            end
            W_DATA:  S_AXI_WREADY  = 1'b1;
            W_ADDR:  S_AXI_AWREADY = 1'b1;
            W_RESP:  S_AXI_BVALID  = 1'b1;
            default: ;
        endcase
    end

    // Whichever channel arrived first is taken from its holding register.
    assign wr_addr = (wr_state == W_DATA) ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = (wr_state == W_ADDR) ? wdata_q  : S_AXI_WDATA;
    assign wr_strb = (wr_state == W_ADDR) ? wstrb_q  : S_AXI_WSTRB;
    assign wr_idx  = wr_addr[6:2];
    assign wr_ok   = (wr_addr[C_ADDR_W-1:7] == '0) && (32'(wr_idx) < C_NUM_REGS);

`ifdef DP_TEST_AXI_REGS_WSTRB_EN
    assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
`else
    logic unused_strb;
    assign wr_mask     = '1;
    assign unused_strb = &{1'b0, wr_strb};
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            S_AXI_BRESP <= RESP_OKAY;
        end else begin
            if (wr_state == W_IDLE && aw_hs && !w_hs) awaddr_q <= S_AXI_AWADDR;
            if (wr_state == W_IDLE && w_hs && !aw_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_commit) S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_cfg
        localparam logic [31:0] RST_VAL = (i == 0) ? C_CTRL_RST : 32'h0;
        logic [31:0] word_q;
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN)
                word_q <= RST_VAL;
            else if (wr_commit && wr_ok && (wr_idx == 5'(i)))
                word_q <= (word_q & ~wr_mask) | (wr_data & wr_mask);
        end
        assign CFG[i*32 +: 32] = word_q;
    end

    assign SOFT_RST = CFG[0];

    assign rd_idx = S_AXI_ARADDR[6:2];

    always_comb begin
        rd_word = 32'h0;
        rd_resp = RESP_SLVERR;
        if (S_AXI_ARADDR[C_ADDR_W-1:7] == '0) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (rd_idx == 5'(i)) begin
                    rd_word = CFG[i*32 +: 32];
                    rd_resp = RESP_OKAY;
                end
            end
            if (32'(rd_idx) == C_NUM_REGS) begin
                rd_word = STATUS;
                rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rd_state <= R_IDLE;
        else          rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = (rd_state == R_IDLE) && rst_done;
        S_AXI_RVALID  = (rd_state == R_DATA);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_RDATA <= 32'h0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RDATA <= rd_word;
            S_AXI_RRESP <= rd_resp;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE,
                         S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire
